// File: rtl/acc_core_gen2_if.sv
// Host-side bus of the accumulator core:
// program load port, run strobe and status.
interface acc_core_gen2_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          run;
  logic [DW-1:0] ac_out;
  logic [AW-1:0] pc_out;
  logic          zero_flag;
  logic          carry_flag;
  logic          busy;
  logic          halted;
  logic          illegal;

  modport master (
    output load_we, load_addr, load_data, run,
    input  ac_out, pc_out, zero_flag,
    input  carry_flag, busy, halted, illegal
  );

  modport slave (
    input  load_we, load_addr, load_data, run,
    output ac_out, pc_out, zero_flag,
    output carry_flag, busy, halted, illegal
  );
endinterface

// File: rtl/acc_core_gen2.sv
// Accumulator core: two-word instructions,
// FETCH/DECODE/EXECUTE sequencing, private program RAM.
module acc_core_gen2 #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input logic            clk,
  input logic            rst_n,
  acc_core_gen2_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ac;
  logic [DW-1:0] opr;
  logic [7:0]    opc;
  logic [AW-1:0] pc;
  logic          z;
  logic          c;
  logic          ill;
  logic          busy_q;
  logic          halt_q;

  logic          parked;
  logic [DW:0]   add_r;
  logic [DW:0]   sub_r;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_we;
  logic          take_jmp;
  logic          bad_op;
  logic          stop;

  assign parked = (state == S_IDLE) || (state == S_HALT);

  // RAM has no reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (bus.load_we && parked)
      mem[bus.load_addr] <= bus.load_data;
  end

  assign add_r = {1'b0, ac} + {1'b0, opr}
               + {{DW{1'b0}}, (opc == 8'h0E) & c};
  assign sub_r = {1'b0, ac} - {1'b0, opr};

  always_comb begin
    alu_res = ac;
    alu_c   = c;
    alu_we  = 1'b1;
    unique case (opc)
      8'h01: begin alu_res = opr; alu_c = 1'b0; end
      8'h02, 8'h0E: {alu_c, alu_res} = add_r;
      8'h03: {alu_c, alu_res} = sub_r;
      8'h04: begin alu_res = ac & opr; alu_c = 1'b0; end
      8'h05: begin alu_res = ac | opr; alu_c = 1'b0; end
      8'h06: begin alu_res = ac ^ opr; alu_c = 1'b0; end
      8'h07: begin alu_res = ~ac; alu_c = 1'b0; end
      8'h08: begin
        alu_res = {ac[DW-2:0], 1'b0};
        alu_c   = ac[DW-1];
      end
      8'h09: begin
        alu_res = {1'b0, ac[DW-1:1]};
        alu_c   = ac[0];
      end
      default: alu_we = 1'b0;
    endcase
  end

  assign take_jmp = (opc == 8'h0B)
                  | ((opc == 8'h0C) & z)
                  | ((opc == 8'h0D) & c);
  assign bad_op   = opc > 8'h0E;
  assign stop     = bad_op | (opc == 8'h0A);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      ac     <= '0;
      opc    <= '0;
      opr    <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      ill    <= 1'b0;
      busy_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (bus.run) begin
            state  <= S_FETCH;
            pc     <= '0;
            ill    <= 1'b0;
            busy_q <= 1'b1;
            halt_q <= 1'b0;
          end
        end
        S_FETCH: begin
          opc   <= mem[pc][7:0];
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          opr   <= mem[pc];
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_we) begin
            ac <= alu_res;
            c  <= alu_c;
            z  <= (alu_res == '0);
          end
          if (take_jmp)
            pc <= opr[AW-1:0];
          if (stop) begin
            state  <= S_HALT;
            ill    <= bad_op;
            busy_q <= 1'b0;
            halt_q <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          halt_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ac_out     = ac;
  assign bus.pc_out     = pc;
  assign bus.zero_flag  = z;
  assign bus.carry_flag = c;
  assign bus.busy       = busy_q;
  assign bus.halted     = halt_q;
  assign bus.illegal    = ill;
endmodule

// File: tb/tb_acc_core_gen2.sv
// Bench for acc_core_gen2: instruction-level model
// expands each instruction into its expected 3-cycle trace.
module tb_acc_core_gen2;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  acc_core_gen2_if #(.DW(DW), .AW(AW)) bus();

  acc_core_gen2 #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int pc;
    int ac;
    bit z;
    bit c;
    bit busy;
    bit halted;
    bit ill;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   armed       = 1'b0;
  int   busy_cnt    = 0;

  int m_mem [DEPTH];
  int m_ac;
  int m_pc;
  bit m_z;
  bit m_c;
  bit m_ill;

  function automatic void push(int pc, bit b, bit h);
    exp_t e;
    e.pc     = pc % DEPTH;
    e.ac     = m_ac;
    e.z      = m_z;
    e.c      = m_c;
    e.busy   = b;
    e.halted = h;
    e.ill    = m_ill;
    q.push_back(e);
  endfunction

  function automatic void set_ac(int v, bit cy);
    m_ac = v & 255;
    m_z  = (m_ac == 0);
    m_c  = cy;
  endfunction

  // Instruction-set model; returns 1 if the program halts.
  function automatic bit sim(int max_i);
    m_pc  = 0;
    m_ill = 1'b0;
    for (int n = 0; n < max_i; n++) begin
      int op;
      int opr;
      int s;
      bit hlt;
      hlt = 1'b0;
      push(m_pc, 1'b1, 1'b0);
      push(m_pc + 1, 1'b1, 1'b0);
      push(m_pc + 2, 1'b1, 1'b0);
      op   = m_mem[m_pc] & 255;
      opr  = m_mem[(m_pc + 1) % DEPTH] & 255;
      m_pc = (m_pc + 2) % DEPTH;
      case (op)
        'h00: ;
        'h01: set_ac(opr, 1'b0);
        'h02: begin
          s = m_ac + opr;
          set_ac(s, s > 255);
        end
        'h03: set_ac(m_ac - opr, m_ac < opr);
        'h04: set_ac(m_ac & opr, 1'b0);
        'h05: set_ac(m_ac | opr, 1'b0);
        'h06: set_ac(m_ac ^ opr, 1'b0);
        'h07: set_ac(~m_ac, 1'b0);
        'h08: set_ac(m_ac * 2, m_ac >= 128);
        'h09: set_ac(m_ac / 2, (m_ac % 2) == 1);
        'h0A: hlt = 1'b1;
        'h0B: m_pc = opr % DEPTH;
        'h0C: if (m_z) m_pc = opr % DEPTH;
        'h0D: if (m_c) m_pc = opr % DEPTH;
        'h0E: begin
          s = m_ac + opr + int'(m_c);
          set_ac(s, s > 255);
        end
        default: begin
          m_ill = 1'b1;
          hlt   = 1'b1;
        end
      endcase
      if (hlt) begin
        push(m_pc, 1'b0, 1'b1);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (armed && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (bus.busy === 1'b1)
        busy_cnt++;
      if (bus.pc_out !== e.pc[AW-1:0] ||
          bus.ac_out !== e.ac[DW-1:0] ||
          bus.zero_flag !== e.z ||
          bus.carry_flag !== e.c ||
          bus.busy !== e.busy ||
          bus.halted !== e.halted ||
          bus.illegal !== e.ill) begin
        miscompares++;
        $display("FAIL trace t=%0t got pc=%0h ac=%0h z%b c%b b%b h%b i%b want pc=%0h ac=%0h z%b c%b b%b h%b i%b",
          $time, bus.pc_out, bus.ac_out, bus.zero_flag,
          bus.carry_flag, bus.busy, bus.halted, bus.illegal,
          e.pc, e.ac, e.z, e.c, e.busy, e.halted, e.ill);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input int a, input int d);
    @(posedge clk);
    #1;
    bus.load_we   = 1'b1;
    bus.load_addr = AW'(a);
    bus.load_data = DW'(d);
    m_mem[a]      = d & 255;
    @(posedge clk);
    #1;
    bus.load_we = 1'b0;
  endtask

  // Word 0 goes in with the run strobe itself.
  task automatic load_prog(input int p[$]);
    m_mem[0] = p[0] & 255;
    for (int i = 1; i < p.size(); i++)
      load(i, p[i]);
  endtask

  task automatic model_reset();
    m_ac  = 0;
    m_z   = 1'b0;
    m_c   = 1'b0;
    m_pc  = 0;
    m_ill = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic run_prog(input int max_i, input bit poke, output bit hlt);
    int k;
    hlt = sim(max_i);
    @(posedge clk);
    #1;
    bus.load_we   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = DW'(m_mem[0]);
    bus.run       = 1'b1;
    @(posedge clk);
    armed    = 1'b1;
    busy_cnt = 0;
    #1;
    bus.run     = 1'b0;
    bus.load_we = 1'b0;
    if (poke) begin
      @(posedge clk);
      #1;
      bus.load_we   = 1'b1;
      bus.load_addr = AW'(1);
      bus.load_data = ~DW'(m_mem[1]);
      @(posedge clk);
      #1;
      bus.load_we = 1'b0;
    end
    k = 0;
    while (q.size() > 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL timeout: %0d trace entries left, want 0", q.size());
      q.delete();
    end
    armed = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[$];
    bit h;
    bus.load_we   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.run       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("rst_ac", int'(bus.ac_out), 0);
    chk("rst_pc", int'(bus.pc_out), 0);
    chk("rst_z", int'(bus.zero_flag), 0);
    chk("rst_c", int'(bus.carry_flag), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_halt", int'(bus.halted), 0);
    chk("rst_ill", int'(bus.illegal), 0);
    for (int i = 0; i < DEPTH; i++)
      load(i, 0);

    p = '{'h01, 'h05, 'h02, 'h03, 'h0A, 'h00};
    load_prog(p);
    run_prog(50, 1'b0, h);
    chk("p1_ac", int'(bus.ac_out), 8);
    chk("p1_z", int'(bus.zero_flag), 0);
    chk("p1_c", int'(bus.carry_flag), 0);
    chk("p1_pc", int'(bus.pc_out), 6);
    chk("p1_halt", int'(bus.halted), 1);
    chk("p1_cycles", busy_cnt, 9);

    p = '{'h01, 'hFF, 'h02, 'h01, 'h0A, 'h00};
    load_prog(p);
    run_prog(50, 1'b0, h);
    chk("p2_ac", int'(bus.ac_out), 0);
    chk("p2_z", int'(bus.zero_flag), 1);
    chk("p2_c", int'(bus.carry_flag), 1);
    p = '{'h0E, 'h00, 'h0A, 'h00};
    load_prog(p);
    run_prog(50, 1'b1, h);
    chk("p2_adc_ac", int'(bus.ac_out), 1);
    chk("p2_adc_c", int'(bus.carry_flag), 0);
    chk("p2_adc_z", int'(bus.zero_flag), 0);
    run_prog(50, 1'b0, h);
    chk("p2_rerun_ac", int'(bus.ac_out), 1);

    p = '{'h01, 'h03, 'h03, 'h05, 'h0D, 'h0A, 'h01, 'h00,
          'h0A, 'h00, 'h0C, 'h14, 'h0A, 'h00};
    load_prog(p);
    run_prog(50, 1'b0, h);
    chk("p3_ac", int'(bus.ac_out), 'hFE);
    chk("p3_c", int'(bus.carry_flag), 1);
    chk("p3_pc", int'(bus.pc_out), 'h0E);

    p = '{'h20};
    load_prog(p);
    run_prog(50, 1'b0, h);
    chk("p4_ill", int'(bus.illegal), 1);
    chk("p4_halt", int'(bus.halted), 1);
    chk("p4_ac", int'(bus.ac_out), 'hFE);
    chk("p4_pc", int'(bus.pc_out), 2);
    p = '{'h0A};
    load_prog(p);
    run_prog(50, 1'b0, h);
    chk("p4_clr_ill", int'(bus.illegal), 0);

    load(30, 'h01);
    load(31, 'h5A);
    p = '{'h0B, 'h1E};
    load_prog(p);
    run_prog(10, 1'b0, h);
    chk("wrap_busy", int'(bus.busy), 1);
    chk("wrap_ac", int'(bus.ac_out), 'h5A);
    do_reset();
    chk("wrap_rst_busy", int'(bus.busy), 0);

    p = '{'h01, 'hAA, 'h0A, 'h00};
    load_prog(p);
    run_prog(50, 1'b0, h);
    chk("p6_pre_ac", int'(bus.ac_out), 'hAA);
    p = '{'h01, 'h01, 'h0A, 'h00};
    load_prog(p);
    @(posedge clk);
    #1;
    bus.load_we   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = 8'h01;
    bus.run       = 1'b1;
    @(posedge clk);
    #1;
    bus.run     = 1'b0;
    bus.load_we = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("p6_ac", int'(bus.ac_out), 0);
    chk("p6_busy", int'(bus.busy), 0);
    chk("p6_pc", int'(bus.pc_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("p6_idle", int'(bus.busy), 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int w;
        int sel;
        sel = int'($urandom_range(0, 19));
        if (sel < 16)
          w = sel % 15;
        else if (sel < 18)
          w = int'($urandom_range(15, 255));
        else
          w = int'($urandom_range(0, 255));
        if (i == 0)
          m_mem[0] = w;
        else
          load(i, w);
      end
      run_prog(30, r[0], h);
      if (!h)
        do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
